// File: rtl/llki_key_sequencer.sv
// ============================================================================
// Module      : llki_key_sequencer
// Description : Buffers 64-bit key words and runs LOAD/CLEAR commands over the
//               LLKI discrete handshake, returning one status per command.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module llki_key_sequencer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wdata_valid,
    input  logic [63:0]                     wdata,
    output logic                            wdata_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_op,
    input  logic [7:0]                      cmd_num_words,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [1:0]                      rsp_status,
    output logic                            busy,
    output logic [63:0]                     llkid_key_data,
    output logic                            llkid_key_valid,
    input  logic                            llkid_key_ready,
    input  logic                            llkid_key_complete,
    output logic                            llkid_clear_key,
    input  logic                            llkid_clear_key_ack
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [7:0]    LEN_MAX  = 8'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BAD_LEN = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_BAD_OP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_WAIT_WORD     = 3'd1,
        S_SEND          = 3'd2,
        S_WAIT_ACCEPT   = 3'd3,
        S_WAIT_NEXT     = 3'd4,
        S_WAIT_COMPLETE = 3'd5,
        S_CLEAR_REQ     = 3'd6,
        S_RESP          = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    words_left_q, words_left_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    status_q, status_d;

    logic w_pop, w_push, w_flush, w_tmo_go, w_empty, w_full, w_wait_state;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == DEPTH_C);

    always_comb begin
        state_d         = state_q;
        words_left_d    = words_left_q;
        status_d        = status_q;
        w_pop           = 1'b0;
        w_flush         = 1'b0;
        w_tmo_go        = 1'b0;
        w_wait_state    = 1'b0;
        llkid_key_valid = 1'b0;
        llkid_clear_key = 1'b0;
        cmd_ready       = 1'b0;
        rsp_valid       = 1'b0;
        busy            = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    words_left_d = cmd_num_words;
                    if (cmd_op == OP_LOAD) begin
                        if (cmd_num_words == 8'd0 || cmd_num_words > LEN_MAX) begin
                            status_d = ST_BAD_LEN;
                            state_d  = S_RESP;
                        end else begin
                            state_d = S_WAIT_WORD;
                        end
                    end else if (cmd_op == OP_CLEAR) begin
                        w_flush = 1'b1;
                        state_d = S_CLEAR_REQ;
                    end else begin
                        status_d = ST_BAD_OP;
                        state_d  = S_RESP;
                    end
                end
            end
            S_WAIT_WORD: begin
                w_wait_state = 1'b1;
                if (!w_empty && llkid_key_ready) state_d  = S_SEND;
                else if (tmo_q == TMO_MAX)       w_tmo_go = 1'b1;
            end
            S_SEND: begin
                llkid_key_valid = 1'b1;
                w_pop           = 1'b1;
                words_left_d    = words_left_q - 8'd1;
                state_d         = S_WAIT_ACCEPT;
            end
            S_WAIT_ACCEPT: begin
                w_wait_state = 1'b1;
                if (!llkid_key_ready)
                    state_d = (words_left_q == 8'd0) ? S_WAIT_COMPLETE : S_WAIT_NEXT;
                else if (tmo_q == TMO_MAX)
                    w_tmo_go = 1'b1;
            end
            S_WAIT_NEXT: begin
                w_wait_state = 1'b1;
                if (llkid_key_ready)       state_d  = S_WAIT_WORD;
                else if (tmo_q == TMO_MAX) w_tmo_go = 1'b1;
            end
            S_WAIT_COMPLETE: begin
                // complete is only trusted after ready fell for the last word
                w_wait_state = 1'b1;
                if (llkid_key_complete) begin
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (tmo_q == TMO_MAX) begin
                    w_tmo_go = 1'b1;
                end
            end
            S_CLEAR_REQ: begin
                w_wait_state    = 1'b1;
                llkid_clear_key = 1'b1;
                if (llkid_clear_key_ack) begin
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (tmo_q == TMO_MAX) begin
                    w_tmo_go = 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        if (w_tmo_go) begin
            w_flush  = 1'b1;
            status_d = ST_TIMEOUT;
            state_d  = S_RESP;
        end
    end

    always_comb begin
        tmo_d = tmo_q;
        if (state_d != state_q)                  tmo_d = '0;
        else if (w_wait_state && tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
    end

    // A flush discards any word offered in the same cycle, so refuse it.
    assign wdata_ready = !w_full && (state_q != S_CLEAR_REQ) && !w_flush;
    assign w_push      = wdata_valid && wdata_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CW'(w_push) - CW'(w_pop);
        if (w_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        if (w_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            words_left_q <= '0;
            tmo_q        <= '0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            words_left_q <= words_left_d;
            tmo_q        <= tmo_d;
            status_q     <= status_d;
        end
    end

    assign llkid_key_data = llkid_key_valid ? mem_q[rd_ptr_q] : 64'd0;
    assign fifo_count     = count_q;
    assign rsp_status     = status_q;

endmodule

`default_nettype wire

// File: tb/tb_llki_key_sequencer.sv
// ============================================================================
// Module      : tb_llki_key_sequencer
// Description : Randomized self-checking bench with a mock TSS and a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_llki_key_sequencer;

    localparam int DEPTH = 8;
    localparam int TMO   = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wdata_valid;
    logic [63:0] wdata;
    logic        wdata_ready;
    logic [3:0]  fifo_count;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_num_words;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic        busy;
    logic [63:0] llkid_key_data;
    logic        llkid_key_valid;
    logic        tss_ready;
    logic        tss_complete;
    logic        llkid_clear_key;
    logic        tss_ack;

    always #5 clk = ~clk;

    llki_key_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .wdata_valid        (wdata_valid),
        .wdata              (wdata),
        .wdata_ready        (wdata_ready),
        .fifo_count         (fifo_count),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_op             (cmd_op),
        .cmd_num_words      (cmd_num_words),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_status         (rsp_status),
        .busy               (busy),
        .llkid_key_data     (llkid_key_data),
        .llkid_key_valid    (llkid_key_valid),
        .llkid_key_ready    (tss_ready),
        .llkid_key_complete (tss_complete),
        .llkid_clear_key    (llkid_clear_key),
        .llkid_clear_key_ack(tss_ack)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: words leave the sequencer in exactly the order they entered.
    logic [63:0] mdl_q[$];
    int          pulses;
    int          first_valid_cyc;
    int          acc_cyc;

    always @(negedge clk) begin
        if (rst_n && llkid_key_valid) begin
            pulses++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (mdl_q.size() == 0) check("key_word_unexpected", 1, 0);
            else                   check("key_word", llkid_key_data, mdl_q.pop_front());
        end
    end

    // Mock TSS: registered ready, random re-ready delay, complete after tss_kw words.
    logic [63:0] tss_key [8];
    int          tss_idx;
    int          tss_dly;
    int          tss_kw   = 2;
    bit          tss_hold = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tss_ready    <= 1'b1;
            tss_complete <= 1'b0;
            tss_ack      <= 1'b0;
            tss_idx      <= 0;
            tss_dly      <= 0;
        end else begin
            tss_ack <= 1'b0;
            if (llkid_clear_key && !tss_ack) begin
                tss_ack <= 1'b1;
                for (int i = 0; i < 8; i++) tss_key[i] <= 64'd0;
                tss_idx      <= 0;
                tss_complete <= 1'b0;
            end
            if (llkid_key_valid && tss_ready && !tss_hold) begin
                tss_key[tss_idx] <= llkid_key_data;
                tss_ready        <= 1'b0;
                tss_dly          <= $urandom_range(0, 3);
                if (tss_idx + 1 >= tss_kw) begin
                    tss_idx      <= 0;
                    tss_complete <= 1'b1;
                end else begin
                    tss_idx <= tss_idx + 1;
                    if (tss_idx == 0) tss_complete <= 1'b0;
                end
            end else if (!tss_ready) begin
                if (tss_dly == 0) tss_ready <= 1'b1;
                else              tss_dly   <= tss_dly - 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] w);
        logic exp_rdy;
        exp_rdy = (mdl_q.size() < DEPTH);
        check("wdata_ready", wdata_ready, exp_rdy);
        if (exp_rdy) begin
            wdata_valid = 1'b1;
            wdata       = w;
            step();
            wdata_valid = 1'b0;
            mdl_q.push_back(w);
        end
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [7:0] len);
        int i;
        pulses          = 0;
        first_valid_cyc = -1;
        cmd_valid       = 1'b1;
        cmd_op          = op;
        cmd_num_words   = len;
        i = 0;
        while (!cmd_ready && i < 100) begin
            step();
            i++;
        end
        if (!cmd_ready) check("cmd_ready_wait", cmd_ready, 1);
        acc_cyc = cyc;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int bound, output logic [1:0] st, output int lat);
        int i;
        i = 0;
        while (!rsp_valid && i < bound) begin
            step();
            i++;
        end
        check("rsp_seen", rsp_valid, 1);
        st  = rsp_status;
        lat = cyc - acc_cyc;
        repeat ($urandom_range(0, 2)) step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("idle_after_rsp", busy, 0);
    endtask

    task automatic check_reset_outs();
        check("rst_wdata_ready", wdata_ready, 1);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_busy", busy, 0);
        check("rst_key_valid", llkid_key_valid, 0);
        check("rst_key_data", llkid_key_data, 0);
        check("rst_clear_key", llkid_clear_key, 0);
        check("rst_fifo_count", fifo_count, 0);
    endtask

    task automatic do_clear();
        logic [1:0] st;
        int         lat;
        issue_cmd(2'b10, 8'd0);
        mdl_q.delete();
        check("clear_key_high", llkid_clear_key, 1);
        check("clear_refuses_push", wdata_ready, 0);
        wait_rsp(100, st, lat);
        check("clear_status", st, 0);
        check("clear_key_dropped", llkid_clear_key, 0);
        check("clear_fifo_empty", fifo_count, 0);
        check("clear_tss_reg", {tss_key[1], tss_key[0]}, 128'd0);
        check("clear_no_key_valid", pulses, 0);
    endtask

    task automatic run_load(input int len, input int bound, input logic [1:0] exp_st);
        logic [1:0] st;
        int         lat;
        tss_kw = len;
        issue_cmd(2'b01, 8'(len));
        wait_rsp(bound, st, lat);
        check("load_status", st, exp_st);
    endtask

    initial begin
        logic [63:0] a, b, w;
        logic [1:0]  st;
        int          lat, n, len, exp_cnt;

        rst_n         = 1'b0;
        wdata_valid   = 1'b0;
        wdata         = '0;
        cmd_valid     = 1'b0;
        cmd_op        = '0;
        cmd_num_words = '0;
        rsp_ready     = 1'b0;
        pulses        = 0;
        first_valid_cyc = -1;
        repeat (3) step();
        check_reset_outs();
        rst_n = 1'b1;
        step();

        // Two-word load, TSS ready immediately
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        push(a);
        push(b);
        check("count_two", fifo_count, 2);
        run_load(2, 200, 2'd0);
        check("load2_pulses", pulses, 2);
        check("load2_latency", first_valid_cyc - acc_cyc, 2);
        check("load2_tss_reg", {tss_key[1], tss_key[0]}, {b, a});
        check("load2_fifo_empty", fifo_count, 0);

        // Illegal lengths and ops leave the FIFO and TSS alone
        push({$urandom, $urandom});
        issue_cmd(2'b01, 8'd0);
        wait_rsp(50, st, lat);
        check("len0_status", st, 1);
        issue_cmd(2'b01, 8'(DEPTH + 1));
        wait_rsp(50, st, lat);
        check("len_over_status", st, 1);
        check("bad_len_no_valid", pulses, 0);
        issue_cmd(2'b11, 8'd2);
        wait_rsp(50, st, lat);
        check("op11_status", st, 3);
        issue_cmd(2'b00, 8'd2);
        wait_rsp(50, st, lat);
        check("op00_status", st, 3);
        check("bad_op_no_valid", pulses, 0);
        check("bad_cmd_fifo_kept", fifo_count, 1);

        // Randomized loads with occasional clears
        for (int it = 0; it < 16; it++) begin
            n = $urandom_range(0, DEPTH - mdl_q.size());
            for (int k = 0; k < n; k++) push({$urandom, $urandom});
            if (mdl_q.size() == 0) push({$urandom, $urandom});
            len     = $urandom_range(1, mdl_q.size());
            exp_cnt = mdl_q.size() - len;
            run_load(len, 300, 2'd0);
            check("rand_pulses", pulses, len);
            check("rand_fifo_count", fifo_count, exp_cnt);
            if (it % 5 == 4) do_clear();
        end

        // Clear with data pending
        push({$urandom, $urandom});
        push({$urandom, $urandom});
        do_clear();

        // Underflow: load waits for late words
        tss_kw = 3;
        issue_cmd(2'b01, 8'd3);
        repeat (50) step();
        check("underflow_busy", busy, 1);
        check("underflow_no_valid", pulses, 0);
        for (int k = 0; k < 3; k++) push({$urandom, $urandom});
        wait_rsp(200, st, lat);
        check("underflow_status", st, 0);
        check("underflow_pulses", pulses, 3);

        // Timeout waiting for words
        run_load(3, 2000, 2'd2);
        lat = cyc - acc_cyc;
        check("tmo_word_no_valid", pulses, 0);
        check("tmo_fifo_empty", fifo_count, 0);

        // Timeout in WAIT_ACCEPT flushes the remaining words
        for (int k = 0; k < 3; k++) push({$urandom, $urandom});
        tss_hold = 1'b1;
        tss_kw   = 1;
        issue_cmd(2'b01, 8'd1);
        wait_rsp(2000, st, lat);
        check("tmo_accept_status", st, 2);
        check("tmo_accept_latency_ok", (lat >= TMO && lat <= TMO + 8), 1);
        check("tmo_accept_pulses", pulses, 1);
        check("tmo_accept_flushed", fifo_count, 0);
        mdl_q.delete();
        tss_hold = 1'b0;

        // Full FIFO refuses pushes
        for (int k = 0; k < DEPTH; k++) push({$urandom, $urandom});
        check("full_count", fifo_count, DEPTH);
        check("full_not_ready", wdata_ready, 0);
        wdata_valid = 1'b1;
        wdata       = {$urandom, $urandom};
        step();
        wdata_valid = 1'b0;
        check("full_count_held", fifo_count, DEPTH);
        run_load(DEPTH, 400, 2'd0);
        check("drain_fifo_empty", fifo_count, 0);

        // Simultaneous push and pop at count 4
        for (int k = 0; k < 4; k++) push({$urandom, $urandom});
        repeat (5) step();
        tss_kw = 1;
        issue_cmd(2'b01, 8'd1);
        step();
        check("pushpop_in_send", llkid_key_valid, 1);
        w           = {$urandom, $urandom};
        wdata_valid = 1'b1;
        wdata       = w;
        step();
        wdata_valid = 1'b0;
        mdl_q.push_back(w);
        check("pushpop_count", fifo_count, 4);
        wait_rsp(200, st, lat);
        check("pushpop_status", st, 0);
        check("pushpop_count_after", fifo_count, 4);

        // Reset while parked in WAIT_ACCEPT
        tss_hold = 1'b1;
        tss_kw   = 2;
        issue_cmd(2'b01, 8'd2);
        repeat (4) step();
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        mdl_q.delete();
        check_reset_outs();
        step();
        check_reset_outs();
        tss_hold = 1'b0;
        rst_n    = 1'b1;
        step();
        push({$urandom, $urandom});
        run_load(1, 200, 2'd0);
        check("post_reset_fifo", fifo_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
